// File: rtl/vga_vram_arbiter_pkg.sv
// Shared constants, scan-state enum and cell-address helper for the VGA VRAM arbiter.
package vga_vram_pkg;

   localparam int CELL_LOG2 = 3;
   localparam int H_ACTIVE  = 640;
   localparam int V_ACTIVE  = 480;
   localparam int COLS      = H_ACTIVE >> CELL_LOG2;   // 80
   localparam int ROWS      = V_ACTIVE >> CELL_LOG2;   // 60
   localparam int VRAM_AW   = 13;                      // holds COLS*ROWS-1 = 4799

   typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} vstate_e;

   // Cell index for a pixel position: row*80 + col, with the multiply done as
   // two shifted adds (row*64 + row*16) so no multiplier is built.
   function automatic logic [VRAM_AW-1:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
      logic [VRAM_AW-1:0] row;
      logic [VRAM_AW-1:0] col;
      row = VRAM_AW'(y >> CELL_LOG2);
      col = VRAM_AW'(x >> CELL_LOG2);
      return (row << 6) + (row << 4) + col;
   endfunction

endpackage

// File: rtl/vga_vram_arbiter_if.sv
// Write-requester bus: level requests with packed address/data, one-hot grant pulse back.
interface vga_vram_arbiter_if #(
   parameter int N_WR = 3,
   parameter int AW   = 13,
   parameter int DW   = 4
);
   logic [N_WR-1:0]    wr_req;
   logic [N_WR*AW-1:0] wr_addr;
   logic [N_WR*DW-1:0] wr_data;
   logic [N_WR-1:0]    wr_gnt;

   modport master (output wr_req, wr_addr, wr_data, input wr_gnt);
   modport slave  (input wr_req, wr_addr, wr_data, output wr_gnt);
endinterface

// File: rtl/vga_vram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
// adv_i gates the whole grant so the caller can veto a slot; nxt_ptr_o is the
// pointer value to load when a grant is taken.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   input  logic          adv_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o,
   output logic [PW-1:0] nxt_ptr_o
);

   // Rotating priority scan starting at the pointer.
   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      if (adv_i) begin
         for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!any_o && req_i[j]) begin
               any_o    = 1'b1;
               gnt_o[j] = 1'b1;
               idx_o    = PW'(j);
            end
         end
      end
   end

   // Pointer moves to one past the winner, wrapping at N-1.
   always_comb begin
      nxt_ptr_o = (idx_o == PW'(N - 1)) ? '0 : idx_o + 1'b1;
   end

endmodule

// File: rtl/vga_vram_arbiter.sv
// VGA VRAM arbiter: one single-port VRAM shared between scan-out reads (fixed
// slots, absolute priority) and N_WR round-robin writers.
// Optional: define VRAM_WR_BLANK_ONLY_EN to restrict write grants to blanking
// (tear-free frame); otherwise writes use every non-display cycle.
// Address/grant decisions are combinational on the current x/y so a display
// read issued in slot cycle T returns data at T+1 and lands in pix_data at T+2.
module vga_vram_arbiter
   import vga_vram_pkg::*;
#(
   parameter int N_WR = 3,
   parameter int DW   = 4,
   parameter int AW   = 13
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [9:0]           x_pos,
   input  logic [9:0]           y_pos,
   vga_vram_arbiter_if.slave    wr,
   output logic [AW-1:0]        mem_addr,
   output logic                 mem_we,
   output logic [DW-1:0]        mem_wdata,
   input  logic [DW-1:0]        mem_rdata,
   output logic [DW-1:0]        pix_data,
   output logic                 pix_valid
);

   localparam int PW    = (N_WR > 1) ? $clog2(N_WR) : 1;
   localparam int CELLS = COLS * ROWS;

   vstate_e          cur_st, state_q;
   logic             disp_slot;
   logic             wr_win;
   logic [N_WR-1:0]  gnt;
   logic             any_gnt;
   logic [PW-1:0]    sel;
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_data;
   logic             in_range;
   logic [AW-1:0]    mem_addr_q;
   logic [DW-1:0]    mem_wdata_q;
   logic             rd_pend_q;
   logic [DW-1:0]    pix_data_q;
   logic             pix_valid_q;

   // Region test and display-slot detection for the current scan position.
   always_comb begin
      cur_st    = (x_pos < 10'(H_ACTIVE) && y_pos < 10'(V_ACTIVE)) ? SCAN : BLANK;
      disp_slot = (cur_st == SCAN) && (x_pos[CELL_LOG2-1:0] == '0);
`ifdef VRAM_WR_BLANK_ONLY_EN
      wr_win    = (cur_st == BLANK);
`else
      wr_win    = !disp_slot;
`endif
   end

   rr_arbiter #(.N(N_WR), .PW(PW)) u_rr (
      .req_i     (wr.wr_req),
      .ptr_i     (rr_ptr_q),
      .adv_i     (wr_win && !rst),
      .gnt_o     (gnt),
      .idx_o     (sel),
      .any_o     (any_gnt),
      .nxt_ptr_o (rr_ptr_d)
   );

   assign sel_addr  = wr.wr_addr[sel*AW +: AW];
   assign sel_data  = wr.wr_data[sel*DW +: DW];
   assign in_range  = sel_addr < AW'(CELLS);
   assign wr.wr_gnt = gnt;

   // VRAM port mux: display read wins, then the granted writer, else hold.
   // Out-of-range writes still take the grant but never raise mem_we.
   always_comb begin
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      mem_we    = 1'b0;
      if (rst) begin
         mem_addr  = '0;
         mem_wdata = '0;
      end else if (disp_slot) begin
         mem_addr = AW'(cell_addr(x_pos, y_pos));
      end else if (any_gnt) begin
         mem_addr  = sel_addr;
         mem_wdata = sel_data;
         mem_we    = in_range;
      end
   end

   // State, pointer, held bus values and the two-stage read/valid pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BLANK;
         rr_ptr_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_pend_q   <= 1'b0;
         pix_data_q  <= '0;
         pix_valid_q <= 1'b0;
      end else begin
         state_q     <= cur_st;
         if (any_gnt) rr_ptr_q <= rr_ptr_d;
         mem_addr_q  <= mem_addr;
         mem_wdata_q <= mem_wdata;
         rd_pend_q   <= disp_slot;
         if (rd_pend_q) pix_data_q <= mem_rdata;
         pix_valid_q <= (state_q == SCAN);
      end
   end

   assign pix_data  = pix_data_q;
   assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed self-checking bench for vga_vram_arbiter with a behavioural VRAM.
// Honours VRAM_WR_BLANK_ONLY_EN to pick the matching SCAN-write scenario.
module tb_vga_vram_arbiter;
   import vga_vram_pkg::*;

   localparam int N_WR = 3;
   localparam int DW   = 4;
   localparam int AW   = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic [9:0]    x_pos, y_pos;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata, mem_rdata, pix_data;
   logic          pix_valid;

   int checks = 0;
   int errors = 0;

   vga_vram_arbiter_if #(.N_WR(N_WR), .AW(AW), .DW(DW)) wr_if ();

   vga_vram_arbiter #(.N_WR(N_WR), .DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .x_pos     (x_pos),
      .y_pos     (y_pos),
      .wr        (wr_if),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .pix_data  (pix_data),
      .pix_valid (pix_valid)
   );

   always #5 clk = ~clk;

   // Behavioural single-port VRAM, registered read.
   logic [DW-1:0] vram [0:8191];
   always_ff @(posedge clk) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      mem_rdata <= vram[mem_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic set_wr(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_if.wr_addr[idx*AW +: AW] = a;
      wr_if.wr_data[idx*DW +: DW] = d;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      wr_if.wr_req = '0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      x_pos = 10'd16; y_pos = 10'd9;
      wr_if.wr_req = 3'b111;
      tick; tick; settle;
      checks++;
      if (wr_if.wr_gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", wr_if.wr_gnt); end
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== 13'd0 || mem_wdata !== 4'd0) begin
         errors++; $display("FAIL reset_mem: got we=%b addr=%0d wdata=%0h expected 0/0/0", mem_we, mem_addr, mem_wdata);
      end
      checks++;
      if (pix_data !== 4'd0 || pix_valid !== 1'b0) begin
         errors++; $display("FAIL reset_pix: got data=%0h valid=%b expected 0/0", pix_data, pix_valid);
      end
      tick;
      x_pos = 10'd650; y_pos = 10'd0;
      rst = 1'b0;
      settle;
      checks++;
      if (wr_if.wr_gnt !== 3'b001 || mem_addr !== 13'd100 || mem_we !== 1'b1 || mem_wdata !== 4'h1) begin
         errors++; $display("FAIL reset_first_gnt: got gnt=%b addr=%0d we=%b wdata=%0h expected 001/100/1/1",
                            wr_if.wr_gnt, mem_addr, mem_we, mem_wdata);
      end
      tick;
      wr_if.wr_req = '0;
   endtask

   task automatic test_round_robin;
      logic [2:0]    exp_g;
      logic [AW-1:0] exp_a;
      logic [DW-1:0] exp_d;
      apply_reset;
      x_pos = 10'd650; y_pos = 10'd0;
      wr_if.wr_req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         settle;
         case (k % 3)
            0:       begin exp_g = 3'b001; exp_a = 13'd100; exp_d = 4'h1; end
            1:       begin exp_g = 3'b010; exp_a = 13'd200; exp_d = 4'h2; end
            default: begin exp_g = 3'b100; exp_a = 13'd300; exp_d = 4'h3; end
         endcase
         checks++;
         if (wr_if.wr_gnt !== exp_g || mem_addr !== exp_a || mem_wdata !== exp_d || mem_we !== 1'b1) begin
            errors++; $display("FAIL rr_seq%0d: got gnt=%b addr=%0d wdata=%0h we=%b expected %b/%0d/%0h/1",
                               k, wr_if.wr_gnt, mem_addr, mem_wdata, mem_we, exp_g, exp_a, exp_d);
         end
         tick;
         x_pos = x_pos + 10'd1;
      end
      wr_if.wr_req = '0;
      settle;
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== 13'd100 || wr_if.wr_gnt !== 3'b000) begin
         errors++; $display("FAIL rr_idle_hold: got we=%b addr=%0d gnt=%b expected 0/100/000", mem_we, mem_addr, wr_if.wr_gnt);
      end
      tick;
      checks++;
      if (vram[100] !== 4'h1 || vram[200] !== 4'h2 || vram[300] !== 4'h3) begin
         errors++; $display("FAIL rr_vram: got %0h %0h %0h expected 1 2 3", vram[100], vram[200], vram[300]);
      end
   endtask

   task automatic test_display_read;
      // Preload cells 82 and 83 through the arbiter during blanking.
      x_pos = 10'd650; y_pos = 10'd0;
      set_wr(0, 13'd82, 4'hA);
      wr_if.wr_req = 3'b001;
      settle; tick;
      set_wr(0, 13'd83, 4'h5);
      settle; tick;
      wr_if.wr_req = '0;
      set_wr(0, 13'd100, 4'h1);
      x_pos = 10'd16; y_pos = 10'd9;
      settle;
      checks++;
      if (mem_addr !== 13'd82 || mem_we !== 1'b0 || pix_valid !== 1'b0) begin
         errors++; $display("FAIL disp_addr: got addr=%0d we=%b valid=%b expected 82/0/0", mem_addr, mem_we, pix_valid);
      end
      for (int c = 1; c <= 10; c++) begin
         tick;
         x_pos = 10'(16 + c);
         settle;
         if (c == 1) begin
            checks++;
            if (pix_valid !== 1'b0) begin errors++; $display("FAIL disp_valid_lag: got %b expected 0", pix_valid); end
         end else if (c <= 9) begin
            checks++;
            if (pix_data !== 4'hA || pix_valid !== 1'b1) begin
               errors++; $display("FAIL disp_hold%0d: got data=%0h valid=%b expected A/1", c, pix_data, pix_valid);
            end
         end else begin
            checks++;
            if (pix_data !== 4'h5) begin errors++; $display("FAIL disp_next_cell: got %0h expected 5", pix_data); end
         end
      end
   endtask

   task automatic test_display_stall;
      x_pos = 10'd7; y_pos = 10'd0;
      wr_if.wr_req = '0;
      set_wr(1, 13'd150, 4'h7);
      settle; tick;
      x_pos = 10'd8;
      wr_if.wr_req = 3'b010;
      settle;
      checks++;
      if (wr_if.wr_gnt !== 3'b000 || mem_we !== 1'b0 || mem_addr !== 13'd1) begin
         errors++; $display("FAIL stall_slot: got gnt=%b we=%b addr=%0d expected 000/0/1", wr_if.wr_gnt, mem_we, mem_addr);
      end
      tick;
      x_pos = 10'd9;
      settle;
      checks++;
      if (wr_if.wr_gnt !== 3'b010 || mem_addr !== 13'd150 || mem_wdata !== 4'h7 || mem_we !== 1'b1) begin
         errors++; $display("FAIL stall_after: got gnt=%b addr=%0d wdata=%0h we=%b expected 010/150/7/1",
                            wr_if.wr_gnt, mem_addr, mem_wdata, mem_we);
      end
      tick;
      // Pointer now at 2; a display slot with all requests pending must not move it.
      wr_if.wr_req = 3'b111;
      x_pos = 10'd16;
      settle;
      checks++;
      if (wr_if.wr_gnt !== 3'b000) begin errors++; $display("FAIL slot_all_req: got %b expected 000", wr_if.wr_gnt); end
      tick;
      x_pos = 10'd17;
      settle;
      checks++;
      if (wr_if.wr_gnt !== 3'b100 || mem_addr !== 13'd300) begin
         errors++; $display("FAIL slot_ptr_kept: got gnt=%b addr=%0d expected 100/300", wr_if.wr_gnt, mem_addr);
      end
      tick;
      wr_if.wr_req = '0;
   endtask

   task automatic test_out_of_range;
      x_pos = 10'd700; y_pos = 10'd0;
      set_wr(0, 13'd4800, 4'hF);
      wr_if.wr_req = 3'b001;
      settle;
      checks++;
      if (wr_if.wr_gnt !== 3'b001 || mem_we !== 1'b0) begin
         errors++; $display("FAIL oor_gnt: got gnt=%b we=%b expected 001/0", wr_if.wr_gnt, mem_we);
      end
      tick;
      wr_if.wr_req = '0;
      set_wr(0, 13'd100, 4'h1);
      tick;
      checks++;
      if (vram[4800] === 4'hF) begin errors++; $display("FAIL oor_vram: got %0h expected untouched", vram[4800]); end
   endtask

`ifdef VRAM_WR_BLANK_ONLY_EN
   task automatic test_blank_only;
      x_pos = 10'd100; y_pos = 10'd10;
      wr_if.wr_req = 3'b100;
      for (int c = 0; c < 4; c++) begin
         settle;
         checks++;
         if (wr_if.wr_gnt !== 3'b000 || mem_we !== 1'b0) begin
            errors++; $display("FAIL blank_only_scan%0d: got gnt=%b we=%b expected 000/0", c, wr_if.wr_gnt, mem_we);
         end
         tick;
         x_pos = x_pos + 10'd1;
      end
      x_pos = 10'd639;
      settle;
      checks++;
      if (wr_if.wr_gnt !== 3'b000) begin errors++; $display("FAIL blank_only_639: got %b expected 000", wr_if.wr_gnt); end
      tick;
      x_pos = 10'd640;
      settle;
      checks++;
      if (wr_if.wr_gnt !== 3'b100 || mem_we !== 1'b1 || mem_addr !== 13'd300) begin
         errors++; $display("FAIL blank_only_640: got gnt=%b we=%b addr=%0d expected 100/1/300", wr_if.wr_gnt, mem_we, mem_addr);
      end
      tick;
      wr_if.wr_req = '0;
   endtask
`else
   task automatic test_scan_write;
      x_pos = 10'd100; y_pos = 10'd10;
      wr_if.wr_req = 3'b100;
      settle;
      checks++;
      if (wr_if.wr_gnt !== 3'b100 || mem_we !== 1'b1 || mem_addr !== 13'd300) begin
         errors++; $display("FAIL scan_write: got gnt=%b we=%b addr=%0d expected 100/1/300", wr_if.wr_gnt, mem_we, mem_addr);
      end
      tick;
      wr_if.wr_req = '0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      x_pos = '0; y_pos = '0;
      wr_if.wr_req = '0;
      set_wr(0, 13'd100, 4'h1);
      set_wr(1, 13'd200, 4'h2);
      set_wr(2, 13'd300, 4'h3);
      test_reset;
      test_round_robin;
      test_display_read;
      test_display_stall;
      test_out_of_range;
`ifdef VRAM_WR_BLANK_ONLY_EN
      test_blank_only;
`else
      test_scan_write;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
